// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and a constant clog2 used to size bit counters.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Smallest r such that 2**r >= v (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i) + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/Ready/Done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ready;
  logic             Done;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
  logic             Overflow;

  modport master (
    output Start, A, B,
    input  Ready, Done, Diff, Borrow, Overflow
  );

  modport slave (
    input  Start, A, B,
    output Ready, Done, Diff, Borrow, Overflow
  );
endinterface

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: D = A - B - Bin with borrow out.
module full_subtractor (
  output logic D,
  output logic Bout,
  input  logic A,
  input  logic B,
  input  logic Bin
);
  always_comb begin
    D    = A ^ B ^ Bin;
    Bout = (~A & B) | (~(A ^ B) & Bin);
  end
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor Diff = A - B, one bit per clock, LSB first.
// Optional signed overflow flag enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CNT_W = clog2(WIDTH + 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             bin_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             done_q;
  logic             borrow_q;
  logic             bit_d;
  logic             bout_d;
  logic             last_bit;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;
  assign bus.Overflow = ovf_q;
`else
  assign bus.Overflow = 1'b0;
`endif

  full_subtractor u_fs (
    .D   (bit_d),
    .Bout(bout_d),
    .A   (a_q[0]),
    .B   (b_q[0]),
    .Bin (bin_q)
  );

  assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));
  assign bus.Ready  = ready_q;
  assign bus.Done   = done_q;
  assign bus.Diff   = diff_q;
  assign bus.Borrow = borrow_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        // IDLE and DONE accept a new operation identically
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.Start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            bin_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ST_SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q <= bus.A[WIDTH-1];
            b_msb_q <= bus.B[WIDTH-1];
`endif
          end else begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          diff_q <= {bit_d, diff_q[WIDTH-1:1]};
          a_q    <= {1'b0, a_q[WIDTH-1:1]};
          b_q    <= {1'b0, b_q[WIDTH-1:1]};
          bin_q  <= bout_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            state_q  <= ST_DONE;
            ready_q  <= 1'b1;
            done_q   <= 1'b1;
            borrow_q <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // bit_d is the result MSB being shifted in this cycle
            ovf_q    <= (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

`ifdef SERIAL_SUB_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst;
  int   checks = 0;
  int   errors = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, borrow, diff} from plain integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int ua, ub, sa, sb, r;
    logic [W-1:0] d;
    logic bo, ov;
    ua = int'(a);
    ub = int'(b);
    d  = W'((ua - ub + 256) % 256);
    bo = (ua < ub);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    r  = sa - sb;
    ov = OVF_EN && ((r > 127) || (r < -128));
    return {ov, bo, d};
  endfunction

  // Advance until Done, checking Ready stays low meanwhile; bounded
  task automatic wait_done(inout int lat);
    while (bus.Done !== 1'b1 && lat < 40) begin
      chk("ready_low_in_shift", 32'(bus.Ready), 32'd0);
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                              input string tag);
    logic [W+1:0] e;
    e = model(a, b);
    chk({tag, "_latency"}, 32'(lat), 32'(W + 1));
    chk({tag, "_ready_at_done"}, 32'(bus.Ready), 32'd1);
    chk({tag, "_diff"}, 32'(bus.Diff), 32'(e[W-1:0]));
    chk({tag, "_borrow"}, 32'(bus.Borrow), 32'(e[W]));
    chk({tag, "_overflow"}, 32'(bus.Overflow), 32'(e[W+1]));
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int lat;
    logic [W+1:0] e;
    e = model(a, b);
    bus.Start = 1'b1;
    bus.A = a;
    bus.B = b;
    tick();
    bus.Start = 1'b0;
    bus.A = W'($urandom);
    bus.B = W'($urandom);
    lat = 1;
    wait_done(lat);
    check_result(a, b, lat, tag);
    tick();
    chk({tag, "_done_one_cycle"}, 32'(bus.Done), 32'd0);
    chk({tag, "_diff_held"}, 32'(bus.Diff), 32'(e[W-1:0]));
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.Done === 1'b1) n++;
    end
  endtask

  initial begin
    int lat;
    int n;
    logic [W-1:0] ra, rb;

    Rst = 1'b1;
    bus.Start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    tick();
    tick();
    Rst = 1'b0;
    chk("rst_ready", 32'(bus.Ready), 32'd1);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_diff", 32'(bus.Diff), 32'd0);
    chk("rst_borrow", 32'(bus.Borrow), 32'd0);
    chk("rst_overflow", 32'(bus.Overflow), 32'd0);
    count_done(20, n);
    chk("idle_no_done", 32'(n), 32'd0);
    chk("idle_ready", 32'(bus.Ready), 32'd1);

    do_op(8'd100, 8'd37, "op_100_37");
    do_op(8'd5, 8'd9, "op_5_9");
    do_op(8'hAA, 8'hAA, "op_aa_aa");
    do_op(8'h80, 8'h01, "op_80_01");
    do_op(8'h00, 8'hFF, "op_00_ff");
    do_op(8'h7F, 8'h80, "op_7f_80");

    // Start pulsed mid-SHIFT with other operands must be ignored
    bus.Start = 1'b1;
    bus.A = 8'd100;
    bus.B = 8'd37;
    tick();
    bus.Start = 1'b0;
    tick();
    tick();
    bus.Start = 1'b1;
    bus.A = 8'h11;
    bus.B = 8'h22;
    tick();
    bus.Start = 1'b0;
    lat = 4;
    wait_done(lat);
    check_result(8'd100, 8'd37, lat, "ignore_start");
    count_done(15, n);
    chk("ignore_start_single_done", 32'(n), 32'd0);

    // Start held high across DONE: back-to-back operations
    bus.Start = 1'b1;
    bus.A = 8'd200;
    bus.B = 8'd55;
    tick();
    bus.A = 8'd5;
    bus.B = 8'd9;
    lat = 1;
    wait_done(lat);
    check_result(8'd200, 8'd55, lat, "b2b_first");
    tick();
    bus.Start = 1'b0;
    lat = 1;
    wait_done(lat);
    check_result(8'd5, 8'd9, lat, "b2b_second");
    tick();
    chk("b2b_no_third", 32'(bus.Ready), 32'd1);

    // Reset during the 4th SHIFT cycle discards the operation
    bus.Start = 1'b1;
    bus.A = 8'h5A;
    bus.B = 8'h33;
    tick();
    bus.Start = 1'b0;
    tick();
    tick();
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("midrst_ready", 32'(bus.Ready), 32'd1);
    chk("midrst_done", 32'(bus.Done), 32'd0);
    chk("midrst_diff", 32'(bus.Diff), 32'd0);
    chk("midrst_borrow", 32'(bus.Borrow), 32'd0);
    chk("midrst_overflow", 32'(bus.Overflow), 32'd0);
    count_done(15, n);
    chk("midrst_no_done", 32'(n), 32'd0);

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(ra, rb, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing Diff = A − B one bit per clock with a borrow chain. It is the inverse-operation companion to the combinational ripple adder datapath. It trades area for latency: a single full-subtractor cell plus shift registers replaces an N-bit ripple chain. It sits behind a simple Start/Ready/Done handshake so a controller FSM can issue operations.

## Interface
- WIDTH, 8, operand and result width in bits (≥2).
- Clk  input  1  rising-edge clock; single clock domain.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only while Ready=1.
- A  input  WIDTH  minuend; captured on accepted Start.
- B  input  WIDTH  subtrahend; captured on accepted Start.
- Ready  output  1  block can accept Start.
- Done  output  1  one-cycle pulse when result is valid.
- Diff  output  WIDTH  result A − B mod 2^WIDTH.
- Borrow  output  1  1 iff A < B (unsigned).
- Overflow  output  1  signed overflow flag; see Configuration.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: Ready=1. If Start=1, capture A/B into shift registers, clear the borrow flop, clear the bit counter, and go to SHIFT.
- SHIFT: Ready=0. Each cycle:
  - Apply the full subtractor to a_lsb, b_lsb, borrow_in, giving d = a^b^bin and bout = (~a&b) | (~(a^b)&bin).
  - Shift d into the MSB of the Diff register (right shift).
  - Shift the A/B registers right.
  - Store bout and increment the counter.
- After the WIDTH-th bit, go to DONE.
- DONE: Done=1, Ready=1, Borrow holds the final bout. A Start in this cycle is accepted exactly as in IDLE and goes to SHIFT. Otherwise the next state is IDLE.
- Start while in SHIFT is ignored. No queueing. Captured operands are unaffected.
- Diff, Borrow and Overflow hold their values from DONE until the next accepted Start. They are undefined (partial) during SHIFT.
- Counter width is clog2(WIDTH+1). The counter never wraps within an operation.

## Timing
- Reset values:
  - state=IDLE, Ready=1, Done=0.
  - Diff=0, Borrow=0, Overflow=0.
  - counter=0, internal borrow=0.
- Rst overrides everything, including a mid-SHIFT operation. The partial result is discarded and no Done is issued.
- Latency: Start high in cycle c. SHIFT runs in cycles c+1..c+WIDTH. Done is high in cycle c+WIDTH+1.
- Throughput: one operation per WIDTH+1 cycles when Start is held high (back-to-back via DONE).
- Done is exactly one cycle wide and never coincides with Ready=0.
- Operands need only be stable in the cycle Start is accepted.

## Configuration
- SERIAL_SUB_OVERFLOW_EN defined:
  - Retain the captured sign bits A[WIDTH-1] and B[WIDTH-1].
  - At the transition to DONE, Overflow = (A_msb≠B_msb) & (Diff_msb≠A_msb).
  - The flag is valid and held alongside Diff.
- Undefined: Overflow is tied to 0, and the sign-capture flops are not instantiated. The port list is unchanged.

## Structure
- Shared package serial_arith_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - A clog2 function for counter sizing.
- Sub-module full_subtractor (ports D, Bout, A, B, Bin) is purely combinational. It is instantiated once in the datapath.
- Top level holds the FSM, counter, operand/result shift registers and borrow flop.

## Test plan
- Reset then idle: Ready=1, Done=0, Diff=0, Borrow=0; Start held low for 20 cycles → no Done.
- WIDTH=8, A=100, B=37, Start 1 cycle → Done exactly 9 cycles after the Start cycle; Diff=63, Borrow=0.
- A=5, B=9 → Diff=8'hFC, Borrow=1; A=8'hAA, B=8'hAA → Diff=0, Borrow=0.
- A=8'h80, B=8'h01 → Diff=8'h7F, Borrow=0; Overflow=1 with SERIAL_SUB_OVERFLOW_EN, 0 without.
- Start pulsed during SHIFT with different operands → ignored; first result is correct and only one Done pulse. Then Start held high across DONE → second operation begins immediately, with Done 9 cycles later.
- Rst asserted in 4th SHIFT cycle → next cycle state=IDLE, Ready=1, outputs zero, no Done pulse.
